conv_maxpool2x2: RTL
====================

Name: conv_maxpool2x2

Overview:
- Downstream stage of the convolution engine: consumes its row-major IEEE-754 single-precision output feature map, one word per accepted beat.
- Performs 2x2, stride-2 max pooling with optional ReLU.
- Emits the pooled map row-major to the next stage.
- Uses a half-row line buffer, so the full map is never stored.

Parameters:
- MAX_DIM, 64, largest supported map_size (feature-map side length); line buffer depth is MAX_DIM/2.
- RELU_EN, 0, 1 = clamp negative pooled results (sign bit set, including -0.0) to 32'h00000000.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches map_size; honoured only in IDLE.
- map_size  in  8  side length N of the square input map (input_size - filter_size + 1).
- in_valid  in  1  in_data holds a feature-map element.
- in_ready  out  1  block can accept; a beat transfers when in_valid && in_ready.
- in_data  in  32  fp32 element, row-major.
- out_valid  out  1  one-cycle strobe; out_data is a pooled element. No backpressure.
- out_data  out  32  fp32 pooled element, row-major, floor(N/2) per row.
- done  out  1  one-cycle pulse at end of frame.
- err  out  1  sticky; set when start carries map_size > MAX_DIM; cleared by the next accepted start or by rst.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, done=0, err=0, state=IDLE, row=col=0. Line buffer contents after reset are don't-care.
- IDLE:
  - start with N=0 -> done pulses next cycle; no beats accepted.
  - start with N > MAX_DIM -> err=1, done pulses next cycle, remain IDLE.
  - Otherwise latch N, clear err, go to RUN.
- RUN:
  - in_ready=1.
  - Per accepted beat, col increments; at col=N-1 it wraps to 0 and row increments.
  - When the final beat (row=N-1, col=N-1) is accepted, go to DONE.
- DONE: in_ready=0; done=1 for exactly one cycle; then IDLE.
- start while in RUN or DONE is ignored.
- Datapath, using P=floor(N/2):
  - Elements with row >= 2P or col >= 2P are accepted and discarded. Odd N drops the last row and column.
  - Even row, even col: hold_reg <= in_data.
  - Even row, odd col: linebuf[col/2] <= max(hold_reg, in_data).
  - Odd row, even col: hold_reg <= in_data.
  - Odd row, odd col: result = max(linebuf[col/2], hold_reg, in_data).
- Output timing:
  - Result is registered; out_valid asserts the cycle after the completing beat is accepted.
  - Latency is 1 cycle. Gaps in in_valid produce matching gaps in out_valid.
  - For even N, the last out_valid coincides with the done pulse.
- fp32 max (combinational, two-input, applied as a tree):
  - Total order on sign-magnitude; +0.0 > -0.0.
  - A NaN operand (exp=8'hFF, mant!=0) loses to a non-NaN operand.
  - Two NaNs produce 32'h7FC00000.
  - Infinities compare normally.
  - No arithmetic is performed, so there is no rounding.
- ReLU is applied after the max when RELU_EN=1.
- rst asserted mid-frame:
  - Next cycle the block is in IDLE with reset values.
  - No done pulse and no further out_valid for the aborted frame.
- Frame output count is exactly P*P.

Test Plan:
- N=4, values 1.0..16.0 row-major, in_valid continuous -> out_data 40C00000, 41000000, 41600000, 41800000 (6, 8, 14, 16). Each arrives 1 cycle after beats 6, 8, 14, 16 respectively; done coincides with the last output.
- N=3, map 7, 9, 11, 15, 17, 19, 23, 25, 27 (the convolution result for a 4x4 input with a 2x2 diagonal filter) -> single output 41880000 (17.0). done one cycle after the 9th beat, with no out_valid on that cycle.
- N=2, window BF800000, C0000000, BF000000, C0400000 -> BF000000 with RELU_EN=0; 00000000 with RELU_EN=1.
- N=2, window 7FC00001, 3F800000, 80000000, 7F800001 -> 3F800000. Window 00000000, 80000000, 80000000, 80000000 -> 00000000. Window of all NaNs -> 7FC00000.
- N=4, in_valid toggled 1-0-1-0 -> same four outputs as the first scenario, each exactly one cycle after its completing beat. start pulsed mid-frame is ignored.
- Reset and error handling:
  - rst asserted after 6 beats -> no out_valid and no done; a new N=4 frame then yields the first scenario's outputs.
  - start with N=200 and MAX_DIM=64 -> err=1, done pulse, in_ready stays 0.

Source files
------------

// File: rtl/conv_maxpool2x2_if.sv
// Stream/control bundle between the convolution engine output and the 2x2 max-pool stage.
// The master side drives the map (upstream), the slave side is the pooling block.
interface conv_maxpool2x2_if;
    logic        start;
    logic [7:0]  map_size;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        done;
    logic        err;

    modport master (
        output start, map_size, in_valid, in_data,
        input  in_ready, out_valid, out_data, done, err
    );

    modport slave (
        input  start, map_size, in_valid, in_data,
        output in_ready, out_valid, out_data, done, err
    );
endinterface

// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 fp32 max pooling over a row-major square map, using a half-row line buffer.
// Optional ReLU clamps negative pooled results (including -0.0) to +0.0.
module conv_maxpool2x2 #(
    parameter int MAX_DIM = 64,
    parameter bit RELU_EN = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    conv_maxpool2x2_if.slave io_bus
);
    localparam int LB_DEPTH = (MAX_DIM / 2 > 1) ? MAX_DIM / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_n;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [31:0] r_hold;
    logic [31:0] r_linebuf [LB_DEPTH];
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_done;
    logic        r_err;

    logic             w_beat;
    logic [7:0]       w_two_p;
    logic             w_keep;
    logic             w_last_col;
    logic             w_last_row;
    logic [LB_AW-1:0] w_lb_idx;
    logic [31:0]      w_pair;
    logic [31:0]      w_pool;
    logic [31:0]      w_result;
    logic             w_too_big;

    // Sign-magnitude total order; a NaN only wins against another NaN (canonical qNaN).
    function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
        logic a_nan;
        logic b_nan;
        logic a_wins;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a[31] != b[31])
            a_wins = ~a[31];
        else if (!a[31])
            a_wins = (a[30:0] >= b[30:0]);
        else
            a_wins = (a[30:0] <= b[30:0]);
        if (a_nan && b_nan)
            return 32'h7FC00000;
        else if (a_nan)
            return b;
        else if (b_nan)
            return a;
        else
            return a_wins ? a : b;
    endfunction

    assign w_beat     = (r_state == ST_RUN) && io_bus.in_valid && r_in_ready;
    assign w_two_p    = {r_n[7:1], 1'b0};
    assign w_keep     = (r_row < w_two_p) && (r_col < w_two_p);
    assign w_last_col = (r_col == r_n - 8'd1);
    assign w_last_row = (r_row == r_n - 8'd1);
    assign w_lb_idx   = r_col[LB_AW:1];
    assign w_pair     = fp_max(r_hold, io_bus.in_data);
    assign w_pool     = fp_max(r_linebuf[w_lb_idx], w_pair);
    assign w_result   = (RELU_EN && w_pool[31]) ? 32'h00000000 : w_pool;
    assign w_too_big  = int'(io_bus.map_size) > MAX_DIM;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_n         <= 8'd0;
            r_row       <= 8'd0;
            r_col       <= 8'd0;
            r_hold      <= 32'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        if (io_bus.map_size == 8'd0) begin
                            r_err  <= 1'b0;
                            r_done <= 1'b1;
                        end else if (w_too_big) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_n        <= io_bus.map_size;
                            r_err      <= 1'b0;
                            r_row      <= 8'd0;
                            r_col      <= 8'd0;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        // Even-col beats seed the pair; odd/odd beat closes the 2x2 window.
                        if (w_keep) begin
                            if (!r_col[0])
                                r_hold <= io_bus.in_data;
                            else if (r_row[0]) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_result;
                            end
                        end
                        if (w_last_col) begin
                            r_col <= 8'd0;
                            r_row <= r_row + 8'd1;
                            if (w_last_row) begin
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= ST_DONE;
                            end
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_row   <= 8'd0;
                    r_col   <= 8'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_beat && w_keep && !r_row[0] && r_col[0])
            r_linebuf[w_lb_idx] <= w_pair;
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
endmodule
